uart_ctrl: RTL and testbench
============================

# uart_ctrl

Memory-mapped serial-port controller between the MIPS CPU data bus and the UART datapath: the receiver (`rx_data`/`rx_status` pulse) and transmitter (`tx_data`/`tx_en`/`tx_status`). It buffers received bytes in an RX FIFO and queues CPU-written bytes in a TX FIFO. A small FSM sequences the transmitter one byte at a time. It maintains the `UART_CON` status/control register and raises the UART interrupt.

## Interface
- `DEPTH`, 4, entries per FIFO (power of 2, ≥2)
- `ADDR_TXD`, 32'h4000_0018, TX data register address
- `ADDR_RXD`, 32'h4000_001C, RX data register address
- `ADDR_CON`, 32'h4000_0020, control/status register address

Ports:
- `clk` in 1: single clock; receiver, transmitter and CPU bus are all synchronous to it
- `reset` in 1: asynchronous, active-high
- `addr` in 32: CPU byte address, full decode
- `rd` in 1: CPU read strobe
- `wr` in 1: CPU write strobe
- `wdata` in 32: CPU write data
- `rdata` out 32: read data, combinational
- `irq` out 1: UART interrupt, level
- `rx_data` in 8: receiver byte
- `rx_status` in 1: one-cycle pulse, `rx_data` valid
- `tx_data` out 8: byte to transmitter
- `tx_en` out 1: one-cycle start pulse to transmitter
- `tx_status` in 1: transmitter busy (high while shifting)

## Operation
- **CON bits:**
  - [0] TX irq enable (RW)
  - [1] RX irq enable (RW)
  - [2] TX done (set when a byte finishes; cleared by a CON read)
  - [3] RX ready (= RX FIFO non-empty, RO)
  - [4] TX busy (FSM not IDLE or TX FIFO non-empty, RO)
  - [5] RX overrun (sticky; cleared by a CON read)
  - [6] TX FIFO full (RO)
  - [31:7] read as 0
- **Writes to CON:** affect only bits [1:0].
- **irq** = (CON[0] & CON[2]) | (CON[1] & CON[3]).
- **RX path:**
  - `rx_status` pushes `rx_data`.
  - If the FIFO is full, the byte is dropped and CON[5] is set.
  - A read of RXD returns {24'b0, head} and pops it.
  - A read of RXD when empty returns 0 with no state change.
- **TX path:**
  - A write to TXD pushes `wdata[7:0]`.
  - If the FIFO is full, the write is ignored and no flag is set beyond CON[6].
- **TX FSM states:**
  - IDLE: if the TX FIFO is non-empty, go to LOAD.
  - LOAD: drive `tx_data` = head, pulse `tx_en`, pop, go to WAIT_START.
  - WAIT_START: when `tx_status` = 1, go to WAIT_DONE.
  - WAIT_DONE: when `tx_status` = 0, set CON[2] and go to IDLE.
- **Other addresses:** reads return 0; writes are ignored. `rd` and `wr` together are legal and act independently.

## Timing
- **Reset values:**
  - `rdata` = 0 (no rd), `irq` = 0, `tx_en` = 0, `tx_data` = 0
  - CON[2,5] = 0 and enables = 0
  - both FIFOs empty; FSM in IDLE
- **Reset mid-operation:** all of the above takes effect immediately, mid-byte included. Bytes queued in the FIFOs are discarded.
- **rdata:** combinational in the same cycle as `rd`. Pops and flag clears take effect at that cycle's clock edge.
- **RX latency:** an `rx_status` pulse at edge N makes CON[3] = 1 and `irq` (if enabled) high after edge N.
- **TX latency:** a TXD write at edge N puts the FSM in LOAD after edge N+1. `tx_en` is high for exactly the cycle between edges N+1 and N+2, and `tx_data` holds stable until the next LOAD.
- **Back-to-back bytes:** minimum gap is IDLE→LOAD, one cycle after `tx_status` falls.
- **Simultaneous events:**
  - Push and pop on the same edge on a full FIFO: both happen, no overrun.
  - Push and pop on an empty FIFO: the pop is a no-op, the push succeeds, and the returned data is 0.
  - Setting CON[2] or CON[5] on the same edge as a CON read: set wins, so no event is lost.
- **Pointers:** `log2(DEPTH)+1`-bit read/write pointers wrap modulo 2·DEPTH. Full when the MSBs differ and the low bits are equal.

## Structure
- **Package `uart_pkg`:**
  - CON bit index constants
  - default register addresses
  - TX FSM state enum: IDLE = 0, LOAD = 1, WAIT_START = 2, WAIT_DONE = 3
- **Sub-module `uart_fifo`:**
  - parameters: DEPTH, width 8
  - ports: push, pop, din, dout (head, combinational), full, empty
  - instantiated twice, once for RX and once for TX

## Test plan
- Reset, write CON = 3, send RX pulse 0x5A → CON reads 0x0B (overrun clear), `irq` = 1. Read RXD → 0x5A; `irq` = 0; CON[3] = 0.
- Five RX pulses 0x01..0x05 with DEPTH = 4 → CON[5] = 1. RXD reads return 01, 02, 03, 04, then 0. The CON read clears bit 5.
- Write TXD 0x41, 0x42; model the transmitter as busy for 20 cycles starting the cycle after `tx_en` → two `tx_en` pulses with `tx_data` 0x41 then 0x42. CON[2] = 1 after each byte; `irq` asserts only if CON[0] = 1.
- Write TXD five times quickly while the transmitter is stalled busy → CON[6] = 1 and the fifth byte never appears on `tx_data`. The first four are sent in order.
- Same-edge RX push and RXD pop on a full FIFO → count unchanged, CON[5] stays 0, and the data order is preserved.
- Assert `reset` in WAIT_DONE with both FIFOs holding data → immediately `tx_en` = 0, CON reads 0, and no further `tx_en` after reset is released.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART controller.
//   - CON register bit positions
//   - default memory-mapped register addresses
//   - transmit sequencer state encoding
package uart_pkg;

    localparam int CON_TX_IE   = 0;  // TX interrupt enable (RW)
    localparam int CON_RX_IE   = 1;  // RX interrupt enable (RW)
    localparam int CON_TX_DONE = 2;  // a byte finished sending (read-clear)
    localparam int CON_RX_RDY  = 3;  // RX FIFO non-empty
    localparam int CON_TX_BUSY = 4;  // sequencer active or bytes queued
    localparam int CON_RX_OVR  = 5;  // RX byte dropped (sticky, read-clear)
    localparam int CON_TX_FULL = 6;  // TX FIFO full

    localparam logic [31:0] DEF_ADDR_TXD = 32'h4000_0018;
    localparam logic [31:0] DEF_ADDR_RXD = 32'h4000_001C;
    localparam logic [31:0] DEF_ADDR_CON = 32'h4000_0020;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD       = 2'd1,
        WAIT_START = 2'd2,
        WAIT_DONE  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: small synchronous FIFO used for both the RX and TX byte queues.
// Ports:
//   clk, reset   clock, asynchronous active-high reset (empties the FIFO)
//   push, din    write request and data; dropped when full unless popping too
//   pop          read request; ignored when empty
//   dout         head entry, combinational; reads 0 when empty
//   full, empty  occupancy flags
module uart_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // A pop on a full FIFO frees the slot in the same edge, so a
    // simultaneous push is still accepted.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout = empty ? '0 : mem[rptr[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_ONE;
            if (do_pop)  rptr <= rptr + PTR_ONE;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: memory-mapped UART controller between the CPU data bus and the
// UART receiver/transmitter. Received bytes are queued in an RX FIFO, CPU
// writes are queued in a TX FIFO and fed to the transmitter one at a time.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   addr, rd, wr, wdata  CPU bus (full address decode)
//   rdata                read data, combinational, 0 when rd is low
//   irq                  level interrupt
//   rx_data, rx_status   received byte and its one-cycle valid pulse
//   tx_data, tx_en       byte to transmit and its one-cycle start pulse
//   tx_status            transmitter busy
import uart_pkg::*;

module uart_ctrl #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] ADDR_TXD = DEF_ADDR_TXD,
    parameter logic [31:0] ADDR_RXD = DEF_ADDR_RXD,
    parameter logic [31:0] ADDR_CON = DEF_ADDR_CON
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq,
    input  logic [7:0]  rx_data,
    input  logic        rx_status,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    input  logic        tx_status
);

    tx_state_t   state;
    tx_state_t   state_nxt;

    logic [1:0]  irq_en;
    logic        tx_done;
    logic        rx_ovr;
    logic [7:0]  tx_hold;
    logic [31:0] con;

    logic        sel_txd;
    logic        sel_rxd;
    logic        sel_con;
    logic        rx_pop;
    logic        con_rd;
    logic        tx_push;
    logic        con_wr;
    logic        tx_pop;
    logic        done_set;
    logic        ovr_set;

    logic [7:0]  rx_head;
    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  tx_head;
    logic        tx_full;
    logic        tx_empty;

    logic        unused_wdata;
    assign unused_wdata = ^wdata[31:2];

    assign sel_txd = (addr == ADDR_TXD);
    assign sel_rxd = (addr == ADDR_RXD);
    assign sel_con = (addr == ADDR_CON);

    assign rx_pop  = rd & sel_rxd;
    assign con_rd  = rd & sel_con;
    assign tx_push = wr & sel_txd;
    assign con_wr  = wr & sel_con;

    // A same-edge RXD read frees a slot, so a full FIFO only overruns
    // when nothing is popped.
    assign ovr_set = rx_status & rx_full & ~rx_pop;

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_status),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[7:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Transmit sequencer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        tx_pop    = 1'b0;
        done_set  = 1'b0;
        case (state)
            IDLE:       if (!tx_empty) state_nxt = LOAD;
            LOAD: begin
                tx_pop    = 1'b1;
                state_nxt = WAIT_START;
            end
            WAIT_START: if (tx_status) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (!tx_status) begin
                    done_set  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default:    state_nxt = IDLE;
        endcase
    end

    // During LOAD the head is presented directly; afterwards the captured
    // copy keeps tx_data steady until the next byte is loaded.
    assign tx_en   = (state == LOAD);
    assign tx_data = (state == LOAD) ? tx_head : tx_hold;

    // Control/status registers. Event sets take priority over the
    // read-clear so an event landing on the read edge is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en  <= 2'b00;
            tx_done <= 1'b0;
            rx_ovr  <= 1'b0;
            tx_hold <= 8'h00;
        end else begin
            if (con_wr) irq_en <= wdata[1:0];
            tx_done <= done_set | (tx_done & ~con_rd);
            rx_ovr  <= ovr_set  | (rx_ovr  & ~con_rd);
            if (state == LOAD) tx_hold <= tx_head;
        end
    end

    always_comb begin
        con              = '0;
        con[CON_TX_IE]   = irq_en[0];
        con[CON_RX_IE]   = irq_en[1];
        con[CON_TX_DONE] = tx_done;
        con[CON_RX_RDY]  = ~rx_empty;
        con[CON_TX_BUSY] = (state != IDLE) | ~tx_empty;
        con[CON_RX_OVR]  = rx_ovr;
        con[CON_TX_FULL] = tx_full;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            if (sel_rxd)      rdata = {24'b0, rx_head};
            else if (sel_con) rdata = con;
        end
    end

    assign irq = (irq_en[0] & tx_done) | (irq_en[1] & ~rx_empty);

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: self-checking bench for uart_ctrl. Register-level behaviour
// is driven from a vector table; transmit bytes are checked by a scoreboard
// queue filled at TXD write time and drained on each tx_en pulse.
module tb_uart_ctrl;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;
    localparam logic [31:0] A_BAD = 32'h4000_0024;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;
    logic [7:0]  rx_data;
    logic        rx_status;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        tx_status;

    always #5 clk = ~clk;

    uart_ctrl #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .wdata     (wdata),
        .rdata     (rdata),
        .irq       (irq),
        .rx_data   (rx_data),
        .rx_status (rx_status),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .tx_status (tx_status)
    );

    int         n_cmp  = 0;
    int         n_err  = 0;
    int         n_txen = 0;
    logic [7:0] sb [$];

    // Transmitter model: busy for 20 cycles starting the cycle after tx_en,
    // or held busy while tx_stall is set.
    logic tx_stall = 1'b0;
    logic txen_s   = 1'b0;
    int   busy_cnt = 0;
    assign tx_status = tx_stall | (busy_cnt != 0);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (reset)          busy_cnt = 0;
        else if (txen_s)    busy_cnt = 20;
        else if (busy_cnt > 0) busy_cnt--;
    end

    // Scoreboard: every tx_en must match the oldest outstanding TXD byte.
    always @(negedge clk) begin
        logic [7:0] exp_b;
        txen_s = tx_en;
        if (tx_en) begin
            n_txen++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_unexpected: got tx_data 0x%02h, required no tx_en", tx_data);
            end else begin
                exp_b = sb.pop_front();
                chk("tx_byte", {24'b0, tx_data}, {24'b0, exp_b});
            end
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rxv;
        logic [7:0]  rxb;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        chk_irq;
        logic        exp_irq;
        string       name;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a,
                                input logic [31:0] d, input logic rv, input logic [7:0] rb,
                                input logic cr, input logic [31:0] er,
                                input logic ci, input logic ei, input string nm);
        vec_t v;
        v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.rxv = rv; v.rxb = rb;
        v.chk_rd = cr; v.exp_rd = er; v.chk_irq = ci; v.exp_irq = ei; v.name = nm;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0; rx_status = 1'b0;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        wr = 1'b1; addr = a; wdata = d;
        step();
        idle();
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic [31:0] mask,
                          input logic [31:0] exp, input string nm);
        rd = 1'b1; addr = a;
        @(negedge clk);
        chk(nm, rdata & mask, exp);
        step();
        idle();
    endtask

    task automatic tx_write(input logic [7:0] b, input bit expect_sent);
        if (expect_sent) sb.push_back(b);
        bus_wr(A_TXD, {24'b0, b});
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_status = 1'b1; rx_data = b;
        step();
        idle();
    endtask

    task automatic wait_txen(input int target, input string nm);
        for (int i = 0; i < 400 && n_txen < target; i++) step();
        chk(nm, n_txen, target);
    endtask

    task automatic wait_irq(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = irq;
        end
        chk(nm, {31'b0, seen}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rx_data = 8'h00;
        reset   = 1'b1;
        step();
        step();
        @(negedge clk);
        chk("rst_rdata",   rdata, 0);
        chk("rst_irq",     {31'b0, irq}, 0);
        chk("rst_tx_en",   {31'b0, tx_en}, 0);
        chk("rst_tx_data", {24'b0, tx_data}, 0);
        step();
        reset = 1'b0;
        step();
        bus_rd(A_CON, 32'hFFFF_FFFF, 32'h0, "rst_con");

        // ---------------- register / RX path vectors ----------------
        tbl.push_back(mk(0, 1, A_CON, 32'h3, 0, 8'h00, 0, 0,      1, 0, "con_wr3"));
        tbl.push_back(mk(0, 0, 0,     0,     1, 8'h5A, 0, 0,      1, 0, "rx_5a"));
        tbl.push_back(mk(1, 0, A_CON, 0,     0, 8'h00, 1, 32'h0B, 1, 1, "con_rx_rdy"));
        tbl.push_back(mk(1, 0, A_RXD, 0,     0, 8'h00, 1, 32'h5A, 1, 1, "rxd_5a"));
        tbl.push_back(mk(1, 0, A_CON, 0,     0, 8'h00, 1, 32'h03, 1, 0, "con_after_pop"));
        tbl.push_back(mk(0, 1, A_CON, 32'h0, 0, 8'h00, 0, 0,      0, 0, "con_wr0"));
        for (int i = 1; i <= 5; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 8'(i), 0, 0, 0, 0, "rx_fill"));
        tbl.push_back(mk(1, 0, A_CON, 0, 0, 8'h00, 1, 32'h28, 1, 0, "con_overrun"));
        tbl.push_back(mk(1, 0, A_CON, 0, 0, 8'h00, 1, 32'h08, 0, 0, "con_overrun_clr"));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1, 0, A_RXD, 0, 0, 8'h00, 1, i, 0, 0, $sformatf("rxd_%0d", i)));
        tbl.push_back(mk(1, 0, A_RXD, 0, 0, 8'h00, 1, 32'h0, 0, 0, "rxd_empty"));
        tbl.push_back(mk(1, 0, A_CON, 0, 0, 8'h00, 1, 32'h0, 0, 0, "con_drained"));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 0, 0, 0, 1, 8'(8'hA0 + i), 0, 0, 0, 0, "rx_fill_a"));
        tbl.push_back(mk(1, 0, A_RXD, 0, 1, 8'hA4, 1, 32'hA0, 0, 0, "rxd_full_pushpop"));
        tbl.push_back(mk(1, 0, A_CON, 0, 0, 8'h00, 1, 32'h08, 0, 0, "con_no_overrun"));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1, 0, A_RXD, 0, 0, 8'h00, 1, 32'hA0 + i, 0, 0,
                             $sformatf("rxd_a%0d", i)));
        tbl.push_back(mk(1, 0, A_RXD, 0, 1, 8'hB0, 1, 32'h0,  0, 0, "rxd_empty_pushpop"));
        tbl.push_back(mk(1, 0, A_RXD, 0, 0, 8'h00, 1, 32'hB0, 0, 0, "rxd_b0"));
        tbl.push_back(mk(1, 1, A_BAD, 32'hFFFF_FFFF, 0, 8'h00, 1, 32'h0, 0, 0, "bad_addr_rd"));
        tbl.push_back(mk(1, 0, A_CON, 0, 0, 8'h00, 1, 32'h0, 0, 0, "con_bad_wr_ignored"));
        tbl.push_back(mk(0, 1, A_CON, 32'hFFFF_FFFF, 0, 8'h00, 0, 0, 0, 0, "con_wr_all"));
        tbl.push_back(mk(1, 0, A_CON, 0, 0, 8'h00, 1, 32'h03, 0, 0, "con_wr_mask"));
        tbl.push_back(mk(0, 1, A_CON, 32'h0, 0, 8'h00, 0, 0, 0, 0, "con_wr0b"));

        foreach (tbl[k]) begin
            rd = tbl[k].rd; wr = tbl[k].wr; addr = tbl[k].addr; wdata = tbl[k].wdata;
            rx_status = tbl[k].rxv; rx_data = tbl[k].rxb;
            @(negedge clk);
            if (tbl[k].chk_rd)  chk(tbl[k].name, rdata, tbl[k].exp_rd);
            if (tbl[k].chk_irq) chk({tbl[k].name, "_irq"}, {31'b0, irq}, {31'b0, tbl[k].exp_irq});
            step();
            idle();
        end

        // ---------------- TX: two bytes, latency and done flag ----------------
        bus_wr(A_CON, 32'h1);
        sb.push_back(8'h41);
        wr = 1'b1; addr = A_TXD; wdata = 32'h41;
        step();
        sb.push_back(8'h42);
        wdata = 32'h42;
        @(negedge clk);
        chk("tx_lat_idle", {31'b0, tx_en}, 0);
        step();
        idle();
        @(negedge clk);
        chk("tx_lat_load", {31'b0, tx_en}, 1);
        chk("tx_lat_data", {24'b0, tx_data}, 32'h41);
        step();
        wait_irq("tx_done1_irq");
        chk("tx_cnt1", n_txen, 1);
        step();
        bus_rd(A_CON, 32'h15, 32'h15, "con_tx_done1");
        @(negedge clk);
        chk("irq_clr1", {31'b0, irq}, 0);
        wait_irq("tx_done2_irq");
        chk("tx_cnt2", n_txen, 2);
        chk("tx_data_hold", {24'b0, tx_data}, 32'h42);
        step();
        bus_rd(A_CON, 32'h14, 32'h04, "con_tx_done2");

        // TX done with its interrupt disabled
        bus_wr(A_CON, 32'h0);
        tx_write(8'h43, 1'b1);
        wait_txen(3, "tx_cnt3");
        for (int i = 0; i < 30; i++) step();
        @(negedge clk);
        chk("irq_tx_masked", {31'b0, irq}, 0);
        step();
        bus_rd(A_CON, 32'h17, 32'h04, "con_tx_done3");

        // ---------------- TX FIFO full while transmitter stalled ----------------
        tx_stall = 1'b1;
        tx_write(8'h60, 1'b1);
        wait_txen(4, "tx_cnt_stall0");
        for (int i = 0; i < 3; i++) step();
        for (int i = 1; i <= 5; i++) tx_write(8'(8'h60 + i), i != 5);
        bus_rd(A_CON, 32'h50, 32'h50, "con_tx_full");
        tx_stall = 1'b0;
        wait_txen(8, "tx_cnt_stall");
        for (int i = 0; i < 40; i++) step();
        chk("sb_drained", sb.size(), 0);
        bus_rd(A_CON, 32'h50, 32'h0, "con_tx_idle");

        // ---------------- reset in WAIT_DONE with both FIFOs loaded ----------------
        bus_wr(A_CON, 32'h3);
        tx_stall = 1'b1;
        tx_write(8'h71, 1'b1);
        wait_txen(9, "tx_cnt_rst0");
        for (int i = 0; i < 3; i++) step();
        tx_write(8'h72, 1'b0);
        tx_write(8'h73, 1'b0);
        rx_push(8'hC1);
        rx_push(8'hC2);
        @(negedge clk);
        chk("pre_rst_irq", {31'b0, irq}, 1);
        #1 reset = 1'b1;
        #1;
        chk("rst_mid_tx_en",   {31'b0, tx_en}, 0);
        chk("rst_mid_tx_data", {24'b0, tx_data}, 0);
        chk("rst_mid_irq",     {31'b0, irq}, 0);
        rd = 1'b1; addr = A_CON;
        #1 chk("rst_mid_con", rdata, 0);
        addr = A_RXD;
        #1 chk("rst_mid_rxd", rdata, 0);
        idle();
        tx_stall = 1'b0;
        step();
        step();
        reset = 1'b0;
        for (int i = 0; i < 40; i++) step();
        chk("rst_no_txen", n_txen, 9);
        bus_rd(A_CON, 32'hFFFF_FFFF, 32'h0, "post_rst_con");
        bus_rd(A_RXD, 32'hFFFF_FFFF, 32'h0, "post_rst_rxd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
